id_branch_unit: RTL and testbench

Decode-stage front end: the receiving end of the fetch-to-decode pipeline interface, and the driver of the branch bus back to fetch. It holds one instruction in the ID pipeline register and resolves LoongArch32R branches/jumps against register-file operands. It drives a one-cycle redirect on `br_bus`, discards the wrong-path instruction already fetched, and passes the surviving `{pc, inst}` to EX under a valid/allow-in handshake.

---
 rtl/id_branch_unit_if.sv | 27 ++
 rtl/id_branch_unit.sv | 156 +++++++++++++++
 tb/tb_id_branch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/id_branch_unit_if.sv
// Fetch-to-decode link: the instruction handshake from IF into ID and the
// branch bus from ID back to IF.
//   IF_to_ID_Valid  fetch presents an instruction on IF_to_ID_Bus
//   IF_to_ID_Bus    {pc[31:0], inst[31:0]}
//   ID_Allow_in     ID pipeline register can accept this cycle
//   br_bus          {br_taken, br_target[31:0], br_stall}
// The master modport is the fetch side; the slave modport is the decode side.
interface id_branch_unit_if;
  logic        IF_to_ID_Valid;
  logic [63:0] IF_to_ID_Bus;
  logic        ID_Allow_in;
  logic [33:0] br_bus;

  modport master (
    output IF_to_ID_Valid,
    output IF_to_ID_Bus,
    input  ID_Allow_in,
    input  br_bus
  );

  modport slave (
    input  IF_to_ID_Valid,
    input  IF_to_ID_Bus,
    output ID_Allow_in,
    output br_bus
  );
endinterface

// File: rtl/id_branch_unit.sv
// Decode-stage front end. Holds one instruction in the ID pipeline register,
// resolves LoongArch32R branches/jumps against forwarded register operands,
// redirects fetch with a one-cycle br_taken pulse, squashes the wrong-path
// instruction already fetched and hands {pc, inst} to EX under valid/allow-in.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   if_id           fetch link (slave): IF_to_ID_Valid/Bus in, ID_Allow_in and br_bus out
//   rf_raddr1/2     register read addresses (rj = inst[9:5], rd = inst[4:0])
//   rf_rdata1/2     forwarded values of rj / rd
//   hazard_stall    operands of the held instruction not yet available
//   EX_Allow_in     EX can accept
//   ID_to_EX_Valid  held instruction leaves ID this cycle
//   ID_to_EX_Bus    {pc, inst} of the held instruction
//
// Build option: define ID_CMP_BRANCH_EN to decode BLT/BGE/BLTU/BGEU;
// without it those opcodes are treated as ordinary instructions.
module id_branch_unit (
  input  logic        clk,
  input  logic        reset,
  id_branch_unit_if.slave if_id,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        hazard_stall,
  input  logic        EX_Allow_in,
  output logic        ID_to_EX_Valid,
  output logic [63:0] ID_to_EX_Bus
);

  localparam logic [5:0] OpJirl = 6'h13;
  localparam logic [5:0] OpB    = 6'h14;
  localparam logic [5:0] OpBl   = 6'h15;
  localparam logic [5:0] OpBeq  = 6'h16;
  localparam logic [5:0] OpBne  = 6'h17;
`ifdef ID_CMP_BRANCH_EN
  localparam logic [5:0] OpBlt  = 6'h18;
  localparam logic [5:0] OpBge  = 6'h19;
  localparam logic [5:0] OpBltu = 6'h1a;
  localparam logic [5:0] OpBgeu = 6'h1b;
`endif

  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  logic        ready_go;
  logic        allow_in;
  logic        is_branch;
  logic        cond_taken;
  logic        br_taken;
  logic        br_stall;
  logic [31:0] br_target;
  logic [31:0] target;
  logic [5:0]  opcode;
  logic [31:0] offs16_ext;
  logic [31:0] offs26_ext;
  logic [31:0] rj_val;
  logic [31:0] rd_val;

  assign ready_go = ~hazard_stall;
  // Reset forces the handshake to its idle shape even before the register clears.
  assign allow_in = reset | ~id_valid_q | (ready_go & EX_Allow_in);

  assign opcode     = id_inst_q[31:26];
  assign offs16_ext = {{14{id_inst_q[25]}}, id_inst_q[25:10], 2'b00};
  // offs26 is split in the encoding: high bits live in inst[9:0].
  assign offs26_ext = {{4{id_inst_q[9]}}, id_inst_q[9:0], id_inst_q[25:10], 2'b00};
  assign rj_val     = rf_rdata1;
  assign rd_val     = rf_rdata2;

  assign rf_raddr1 = id_inst_q[9:5];
  assign rf_raddr2 = id_inst_q[4:0];

  always_comb begin
    is_branch  = 1'b0;
    cond_taken = 1'b0;
    target     = id_pc_q + offs16_ext;
    case (opcode)
      OpJirl: begin
        is_branch  = 1'b1;
        cond_taken = 1'b1;
        target     = rj_val + offs16_ext;
      end
      OpB, OpBl: begin
        is_branch  = 1'b1;
        cond_taken = 1'b1;
        target     = id_pc_q + offs26_ext;
      end
      OpBeq: begin
        is_branch  = 1'b1;
        cond_taken = (rj_val == rd_val);
      end
      OpBne: begin
        is_branch  = 1'b1;
        cond_taken = (rj_val != rd_val);
      end
`ifdef ID_CMP_BRANCH_EN
      OpBlt: begin
        is_branch  = 1'b1;
        cond_taken = ($signed(rj_val) < $signed(rd_val));
      end
      OpBge: begin
        is_branch  = 1'b1;
        cond_taken = ($signed(rj_val) >= $signed(rd_val));
      end
      OpBltu: begin
        is_branch  = 1'b1;
        cond_taken = (rj_val < rd_val);
      end
      OpBgeu: begin
        is_branch  = 1'b1;
        cond_taken = (rj_val >= rd_val);
      end
`endif
      default: ;
    endcase
  end

  // Taken only in the cycle the branch actually leaves ID, so it pulses once.
  assign br_taken  = ~reset & id_valid_q & ready_go & EX_Allow_in & is_branch & cond_taken;
  assign br_stall  = ~reset & id_valid_q & is_branch & ~ready_go;
  assign br_target = br_taken ? target : 32'h0;

  assign if_id.ID_Allow_in = allow_in;
  assign if_id.br_bus      = {br_taken, br_target, br_stall};

  assign ID_to_EX_Valid = ~reset & id_valid_q & ready_go;
  assign ID_to_EX_Bus   = {id_pc_q, id_inst_q};

  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (allow_in) begin
      // The instruction fetched alongside a taken branch is wrong-path: load it invalid.
      id_valid_d = if_id.IF_to_ID_Valid & ~br_taken;
      id_pc_d    = if_id.IF_to_ID_Bus[63:32];
      id_inst_d  = if_id.IF_to_ID_Bus[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= 32'h0;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

endmodule

// File: tb/tb_id_branch_unit.sv
// Bench for id_branch_unit. Instructions expected to reach EX are queued when
// presented to fetch and popped when the DUT hands one to EX; branch bus and
// handshake values are checked directly each scenario cycle.
module tb_id_branch_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        hazard_stall;
  logic        EX_Allow_in;
  logic        ID_to_EX_Valid;
  logic [63:0] ID_to_EX_Bus;

  id_branch_unit_if if_id ();

  id_branch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .if_id          (if_id.slave),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .hazard_stall   (hazard_stall),
    .EX_Allow_in    (EX_Allow_in),
    .ID_to_EX_Valid (ID_to_EX_Valid),
    .ID_to_EX_Bus   (ID_to_EX_Bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [63:0] exp_q[$];

  localparam logic [31:0] Nop = 32'h0280_0000;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i16(input logic [5:0] op, input logic [15:0] offs,
                                          input logic [4:0] rj, input logic [4:0] rd);
    return {op, offs, rj, rd};
  endfunction

  function automatic logic [31:0] enc_i26(input logic [5:0] op, input logic [25:0] offs);
    return {op, offs[15:0], offs[25:16]};
  endfunction

  function automatic logic [33:0] brb(input logic tk, input logic [31:0] tgt, input logic st);
    return {tk, tgt, st};
  endfunction

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input bit keep);
    if_id.IF_to_ID_Valid = v;
    if_id.IF_to_ID_Bus   = {pc, inst};
    if (v && keep) exp_q.push_back({pc, inst});
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && ID_to_EX_Valid && EX_Allow_in) begin
      if (exp_q.size() == 0) begin
        check_eq("ex_extra", {63'b0, ID_to_EX_Valid}, 64'd0);
      end else begin
        check_eq("ex_bus", ID_to_EX_Bus, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    if_id.IF_to_ID_Valid = 1'b0;
    if_id.IF_to_ID_Bus   = 64'h0;
    rf_rdata1 = 32'h0;
    rf_rdata2 = 32'h0;
    hazard_stall = 1'b0;
    EX_Allow_in  = 1'b1;

    // Reset and idle
    tick(); #1;
    check_eq("rst_br_bus", if_id.br_bus, 64'h0);
    check_eq("rst_ex_valid", ID_to_EX_Valid, 64'h0);
    check_eq("rst_allow", if_id.ID_Allow_in, 64'h1);
    reset = 1'b0;
    tick(); #1;
    check_eq("idle_br_bus", if_id.br_bus, 64'h0);
    check_eq("idle_ex_valid", ID_to_EX_Valid, 64'h0);
    check_eq("idle_allow", if_id.ID_Allow_in, 64'h1);

    // B with offs26 = 4
    tick(); present(1'b1, 32'h1c00_0000, enc_i26(6'h14, 26'd4), 1'b1);
    check_eq("b_pre_br_bus", if_id.br_bus, 64'h0);
    tick(); present(1'b1, 32'h1c00_0004, Nop, 1'b0);
    check_eq("b_br_bus", if_id.br_bus, brb(1'b1, 32'h1c00_0010, 1'b0));
    tick(); present(1'b1, 32'h1c00_0010, Nop, 1'b1);
    check_eq("b_br_once", if_id.br_bus, 64'h0);
    check_eq("b_squash", ID_to_EX_Valid, 64'h0);
    tick(); present(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("b_target_ex", ID_to_EX_Valid, 64'h1);
    tick();

    // BEQ taken (rj == rd)
    rf_rdata1 = 32'd5; rf_rdata2 = 32'd5;
    present(1'b1, 32'h1c00_0100, enc_i16(6'h16, 16'hfffe, 5'd1, 5'd2), 1'b1);
    tick(); present(1'b1, 32'h1c00_0104, Nop, 1'b0);
    check_eq("beq_raddr1", rf_raddr1, 64'd1);
    check_eq("beq_raddr2", rf_raddr2, 64'd2);
    check_eq("beq_br_bus", if_id.br_bus, brb(1'b1, 32'h1c00_00f8, 1'b0));
    tick(); present(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("beq_squash", ID_to_EX_Valid, 64'h0);

    // BEQ not taken (rd differs)
    tick(); rf_rdata2 = 32'd6;
    present(1'b1, 32'h1c00_0100, enc_i16(6'h16, 16'hfffe, 5'd1, 5'd2), 1'b1);
    tick(); present(1'b1, 32'h1c00_0104, Nop, 1'b1);
    check_eq("beq_nt_br_bus", if_id.br_bus, 64'h0);
    tick(); present(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("beq_nt_next_ex", ID_to_EX_Valid, 64'h1);
    tick();

    // JIRL held by a two-cycle hazard
    rf_rdata1 = 32'h1c00_1000;
    present(1'b1, 32'h1c00_0200, enc_i16(6'h13, 16'h0003, 5'd3, 5'd1), 1'b1);
    tick(); hazard_stall = 1'b1;
    present(1'b1, 32'h1c00_0204, Nop, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq("jirl_stall_br_bus", if_id.br_bus, brb(1'b0, 32'h0, 1'b1));
      check_eq("jirl_stall_allow", if_id.ID_Allow_in, 64'h0);
      check_eq("jirl_stall_ex_valid", ID_to_EX_Valid, 64'h0);
      tick(); #1;
    end
    hazard_stall = 1'b0; #1;
    check_eq("jirl_br_bus", if_id.br_bus, brb(1'b1, 32'h1c00_100c, 1'b0));
    tick(); present(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("jirl_squash", ID_to_EX_Valid, 64'h0);
    tick();

    // BLT -1 < 1 (signed)
    rf_rdata1 = 32'hffff_ffff; rf_rdata2 = 32'd1;
    present(1'b1, 32'h1c00_0300, enc_i16(6'h18, 16'h0004, 5'd4, 5'd5), 1'b1);
    tick(); present(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef ID_CMP_BRANCH_EN
    check_eq("blt_br_bus", if_id.br_bus, brb(1'b1, 32'h1c00_0310, 1'b0));
`else
    check_eq("blt_br_bus", if_id.br_bus, 64'h0);
`endif
    check_eq("blt_ex_valid", ID_to_EX_Valid, 64'h1);
    tick();
    // BLTU 0xffffffff < 1 unsigned is false
    present(1'b1, 32'h1c00_0400, enc_i16(6'h1a, 16'h0004, 5'd4, 5'd5), 1'b1);
    tick(); present(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("bltu_br_bus", if_id.br_bus, 64'h0);
    check_eq("bltu_ex_valid", ID_to_EX_Valid, 64'h1);
    tick();

    // BNE held while EX refuses for three cycles
    rf_rdata1 = 32'd1; rf_rdata2 = 32'd2;
    present(1'b1, 32'h1c00_0500, enc_i16(6'h17, 16'h0008, 5'd1, 5'd2), 1'b1);
    tick(); EX_Allow_in = 1'b0;
    present(1'b1, 32'h1c00_0504, Nop, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq("bne_hold_allow", if_id.ID_Allow_in, 64'h0);
      check_eq("bne_hold_br_bus", if_id.br_bus, 64'h0);
      check_eq("bne_hold_bus", ID_to_EX_Bus,
               {32'h1c00_0500, enc_i16(6'h17, 16'h0008, 5'd1, 5'd2)});
      tick(); #1;
    end
    EX_Allow_in = 1'b1; #1;
    check_eq("bne_br_bus", if_id.br_bus, brb(1'b1, 32'h1c00_0520, 1'b0));
    tick(); present(1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("bne_squash", ID_to_EX_Valid, 64'h0);

    // Back-to-back non-branches
    tick(); present(1'b1, 32'h1c00_0600, Nop, 1'b1);
    tick(); present(1'b1, 32'h1c00_0604, Nop | 32'h1, 1'b1);
    check_eq("b2b_allow", if_id.ID_Allow_in, 64'h1);
    tick(); present(1'b1, 32'h1c00_0608, Nop | 32'h2, 1'b1);
    check_eq("b2b_ex_valid", ID_to_EX_Valid, 64'h1);
    tick(); present(1'b0, 32'h0, 32'h0, 1'b0);
    tick();

    // Reset while a taken branch is held
    rf_rdata1 = 32'd5; rf_rdata2 = 32'd5;
    present(1'b1, 32'h1c00_0700, enc_i16(6'h16, 16'h0004, 5'd1, 5'd2), 1'b0);
    tick(); present(1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1; #1;
    check_eq("midrst_br_bus", if_id.br_bus, 64'h0);
    tick(); reset = 1'b0; #1;
    check_eq("postrst_br_bus", if_id.br_bus, 64'h0);
    check_eq("postrst_ex_valid", ID_to_EX_Valid, 64'h0);
    check_eq("postrst_allow", if_id.ID_Allow_in, 64'h1);

    tick(); tick();
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
